// File: rtl/arp_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arp_rx_pkg : ARP field layout and constants shared by the ARP RX/TX blocks  |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package arp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [15:0] C_ARP_OP_REQ   = 16'd1;
  localparam logic [15:0] C_ARP_OP_REPLY = 16'd2;
  localparam logic [15:0] C_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] C_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  C_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  C_PLEN_IPV4    = 8'd4;

  localparam logic [7:0]  C_OFF_OPER     = 8'd6;
  localparam logic [7:0]  C_OFF_SHA      = 8'd8;
  localparam logic [7:0]  C_OFF_SPA      = 8'd14;
  localparam logic [7:0]  C_OFF_THA      = 8'd18;
  localparam logic [7:0]  C_OFF_TPA      = 8'd24;
  localparam int unsigned C_ARP_MIN_LEN  = 28;

  function automatic logic in_field(input logic [7:0] idx, input logic [7:0] off,
                                    input logic [7:0] len);
    return (idx >= off) && (idx < (off + len));
  endfunction

endpackage
`default_nettype wire

// File: rtl/arp_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arp_rx : ARP receive parser; fires reply trigger and publishes peer MAC/IP  |
// | Option : ARP_RX_STRICT_CHECK_EN also validates HTYPE/PTYPE/HLEN/PLEN        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module arp_rx
  import arp_rx_pkg::*;
#(
  parameter logic [31:0] P_SRC_IP      = {8'd192, 8'd168, 8'd10, 8'd1},
  parameter int unsigned P_ARP_MIN_LEN = C_ARP_MIN_LEN
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_src_ip,
  input  logic        i_src_ip_valid,
  input  logic [7:0]  i_mac_data,
  input  logic        i_mac_last,
  input  logic        i_mac_valid,
  output logic        o_trig_reply,
  output logic [31:0] o_dst_ip,
  output logic [47:0] o_dst_mac,
  output logic        o_dst_valid
);

  localparam logic [7:0] C_LAST_MIN = 8'(P_ARP_MIN_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  w_idx;
  logic [31:0] lip_q;
  logic [15:0] oper_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic [31:0] tpa_q;
  logic [47:0] dst_mac_q;
  logic [31:0] dst_ip_q;
  logic        w_hdr_ok;
  logic        w_match;
  logic        w_pub;
  logic        w_trig;

  // Outside RECV any valid byte starts a new frame at index 0.
  assign w_idx = (state_q == ST_RECV) ? cnt_q : 8'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RECV: begin
        if (!i_mac_valid) begin
          state_d = ST_DROP;
          cnt_d   = '0;
        end else if (i_mac_last) begin
          state_d = (w_idx >= C_LAST_MIN) ? ST_CHECK : ST_DROP;
          cnt_d   = '0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (i_mac_valid) begin
          if (i_mac_last) begin
            state_d = (w_idx >= C_LAST_MIN) ? ST_CHECK : ST_DROP;
          end else begin
            state_d = ST_RECV;
            cnt_d   = 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lip_q <= P_SRC_IP;
    end else if (i_src_ip_valid) begin
      lip_q <= i_src_ip;
    end
  end

  // Fields are exactly their byte width, so a shift-in per index leaves them aligned.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      oper_q <= '0;
      sha_q  <= '0;
      spa_q  <= '0;
      tpa_q  <= '0;
    end else if (i_mac_valid) begin
      if (in_field(w_idx, C_OFF_OPER, 8'd2)) oper_q <= {oper_q[7:0], i_mac_data};
      if (in_field(w_idx, C_OFF_SHA, 8'd6))  sha_q  <= {sha_q[39:0], i_mac_data};
      if (in_field(w_idx, C_OFF_SPA, 8'd4))  spa_q  <= {spa_q[23:0], i_mac_data};
      if (in_field(w_idx, C_OFF_TPA, 8'd4))  tpa_q  <= {tpa_q[23:0], i_mac_data};
    end
  end

`ifdef ARP_RX_STRICT_CHECK_EN
  logic [47:0] hdr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hdr_q <= '0;
    end else if (i_mac_valid && (w_idx < C_OFF_OPER)) begin
      hdr_q <= {hdr_q[39:0], i_mac_data};
    end
  end

  assign w_hdr_ok = (hdr_q == {C_HTYPE_ETH, C_PTYPE_IPV4, C_HLEN_ETH, C_PLEN_IPV4});
`else
  assign w_hdr_ok = 1'b1;
`endif

  assign w_match = (state_q == ST_CHECK) && (tpa_q == lip_q) && w_hdr_ok;
  assign w_trig  = w_match && (oper_q == C_ARP_OP_REQ);
  assign w_pub   = w_match && ((oper_q == C_ARP_OP_REQ) || (oper_q == C_ARP_OP_REPLY));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dst_mac_q <= '0;
      dst_ip_q  <= '0;
    end else if (w_pub) begin
      dst_mac_q <= sha_q;
      dst_ip_q  <= spa_q;
    end
  end

  // Addresses show the new values in the same cycle as the o_dst_valid pulse.
  assign o_trig_reply = w_trig;
  assign o_dst_valid  = w_pub;
  assign o_dst_mac    = w_pub ? sha_q : dst_mac_q;
  assign o_dst_ip     = w_pub ? spa_q : dst_ip_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arp_rx : directed table-driven bench for arp_rx                          |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_arp_rx;

  typedef struct {
    logic [15:0] op;
    logic [15:0] ptype;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] tip;
    int          len;
    int          abort_at;
    logic        e_trig;
    logic        e_dv;
    logic [47:0] e_mac;
    logic [31:0] e_ip;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_ip;
  logic        src_ip_valid;
  logic [7:0]  mac_data;
  logic        mac_last;
  logic        mac_valid;
  logic        trig_reply;
  logic [31:0] dst_ip;
  logic [47:0] dst_mac;
  logic        dst_valid;

  int n_chk = 0;
  int n_err = 0;
  int trig_n = 0;
  int dv_n = 0;

  vec_t tbl[9];

  arp_rx dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_src_ip       (src_ip),
    .i_src_ip_valid (src_ip_valid),
    .i_mac_data     (mac_data),
    .i_mac_last     (mac_last),
    .i_mac_valid    (mac_valid),
    .o_trig_reply   (trig_reply),
    .o_dst_ip       (dst_ip),
    .o_dst_mac      (dst_mac),
    .o_dst_valid    (dst_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (trig_reply) trig_n <= trig_n + 1;
    if (dst_valid)  dv_n   <= dv_n + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] op, input logic [15:0] ptype,
                              input logic [47:0] smac, input logic [31:0] sip,
                              input logic [31:0] tip, input int len, input int abort_at,
                              input logic e_trig, input logic e_dv,
                              input logic [47:0] e_mac, input logic [31:0] e_ip);
    vec_t v;
    v.op = op; v.ptype = ptype; v.smac = smac; v.sip = sip; v.tip = tip;
    v.len = len; v.abort_at = abort_at; v.e_trig = e_trig; v.e_dv = e_dv;
    v.e_mac = e_mac; v.e_ip = e_ip;
    return v;
  endfunction

  function automatic logic [7:0] fbyte(input vec_t v, input int idx);
    case (idx)
      0: return 8'h00;
      1: return 8'h01;
      2: return v.ptype[15:8];
      3: return v.ptype[7:0];
      4: return 8'h06;
      5: return 8'h04;
      6: return v.op[15:8];
      7: return v.op[7:0];
      8, 9, 10, 11, 12, 13: return v.smac[47 - 8*(idx-8) -: 8];
      14, 15, 16, 17:       return v.sip[31 - 8*(idx-14) -: 8];
      18, 19, 20, 21, 22, 23: return 8'h00;
      24, 25, 26, 27:       return v.tip[31 - 8*(idx-24) -: 8];
      default: return 8'hA5;
    endcase
  endfunction

  // Leaves the bench at the negedge of the cycle after the final accepted byte.
  task automatic drive_frame(input vec_t v, input bit hold);
    int n;
    n = (v.abort_at >= 0) ? v.abort_at : v.len;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mac_valid = 1'b1;
      mac_data  = fbyte(v, i);
      mac_last  = (v.abort_at < 0) && (i == n - 1);
    end
    if (!hold) begin
      @(negedge clk);
      mac_valid = 1'b0;
      mac_last  = 1'b0;
      mac_data  = 8'h00;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t0, d0;
    t0 = trig_n;
    d0 = dv_n;
    drive_frame(v, 1'b0);
    chk({name, ".trig"}, 64'(trig_reply), 64'(v.e_trig));
    chk({name, ".dv"},   64'(dst_valid),  64'(v.e_dv));
    chk({name, ".mac"},  64'(dst_mac),    64'(v.e_mac));
    chk({name, ".ip"},   64'(dst_ip),     64'(v.e_ip));
    repeat (2) @(negedge clk);
    chk({name, ".ntrig"}, 64'(trig_n - t0), 64'(v.e_trig));
    chk({name, ".ndv"},   64'(dv_n - d0),   64'(v.e_dv));
  endtask

  initial begin
    vec_t v;
    int t0;
    rst = 1'b1; src_ip = '0; src_ip_valid = 1'b0;
    mac_data = '0; mac_last = 1'b0; mac_valid = 1'b0;

    tbl[0] = mk(16'd1, 16'h0800, 48'h001122334455, 32'hC0A80A02, 32'hC0A80A01, 46, -1,
                1'b1, 1'b1, 48'h001122334455, 32'hC0A80A02);
    tbl[1] = mk(16'd2, 16'h0800, 48'h66778899AABB, 32'hC0A80A03, 32'hC0A80A01, 28, -1,
                1'b0, 1'b1, 48'h66778899AABB, 32'hC0A80A03);
    tbl[2] = mk(16'd1, 16'h0800, 48'hDEADBEEF0001, 32'hC0A80A04, 32'hC0A80A09, 46, -1,
                1'b0, 1'b0, 48'h66778899AABB, 32'hC0A80A03);
    tbl[3] = mk(16'd3, 16'h0800, 48'hDEADBEEF0002, 32'hC0A80A04, 32'hC0A80A01, 28, -1,
                1'b0, 1'b0, 48'h66778899AABB, 32'hC0A80A03);
    tbl[4] = mk(16'd1, 16'h0800, 48'hDEADBEEF0003, 32'hC0A80A04, 32'hC0A80A01, 21, -1,
                1'b0, 1'b0, 48'h66778899AABB, 32'hC0A80A03);
    tbl[5] = mk(16'd1, 16'h0800, 48'hDEADBEEF0004, 32'hC0A80A04, 32'hC0A80A01, 46, 10,
                1'b0, 1'b0, 48'h66778899AABB, 32'hC0A80A03);
    tbl[6] = mk(16'd1, 16'h0800, 48'h00AABBCCDDEE, 32'hC0A80A05, 32'hC0A80A01, 28, -1,
                1'b1, 1'b1, 48'h00AABBCCDDEE, 32'hC0A80A05);
    tbl[7] = mk(16'd1, 16'h0800, 48'h111111111111, 32'hC0A80A0B, 32'hC0A80A01, 27, -1,
                1'b0, 1'b0, 48'h00AABBCCDDEE, 32'hC0A80A05);
`ifdef ARP_RX_STRICT_CHECK_EN
    tbl[8] = mk(16'd1, 16'h86DD, 48'h010203040506, 32'hC0A80A06, 32'hC0A80A01, 46, -1,
                1'b0, 1'b0, 48'h00AABBCCDDEE, 32'hC0A80A05);
`else
    tbl[8] = mk(16'd1, 16'h86DD, 48'h010203040506, 32'hC0A80A06, 32'hC0A80A01, 46, -1,
                1'b1, 1'b1, 48'h010203040506, 32'hC0A80A06);
`endif

    repeat (3) @(negedge clk);
    chk("rst.trig", 64'(trig_reply), 64'd0);
    chk("rst.dv",   64'(dst_valid),  64'd0);
    chk("rst.mac",  64'(dst_mac),    64'd0);
    chk("rst.ip",   64'(dst_ip),     64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Two requests with no idle cycle between them
    t0 = trig_n;
    drive_frame(tbl[0], 1'b1);
    drive_frame(tbl[6], 1'b0);
    chk("b2b.mac", 64'(dst_mac), 64'h00AABBCCDDEE);
    chk("b2b.ip",  64'(dst_ip),  64'hC0A80A05);
    repeat (2) @(negedge clk);
    chk("b2b.ntrig", 64'(trig_n - t0), 64'd2);

    // Reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mac_valid = 1'b1;
      mac_data  = fbyte(tbl[0], i);
      mac_last  = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    mac_valid = 1'b0;
    #1;
    chk("mrst.mac", 64'(dst_mac), 64'd0);
    chk("mrst.ip",  64'(dst_ip),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[0], "mrst.req");

    // Local IP change
    @(negedge clk);
    src_ip = 32'hC0A80A07;
    src_ip_valid = 1'b1;
    @(negedge clk);
    src_ip_valid = 1'b0;
    v = mk(16'd1, 16'h0800, 48'hA0A1A2A3A4A5, 32'hC0A80A08, 32'hC0A80A07, 28, -1,
           1'b1, 1'b1, 48'hA0A1A2A3A4A5, 32'hC0A80A08);
    run_vec(v, "ip7.hit");
    v = mk(16'd1, 16'h0800, 48'hB0B1B2B3B4B5, 32'hC0A80A0C, 32'hC0A80A01, 28, -1,
           1'b0, 1'b0, 48'hA0A1A2A3A4A5, 32'hC0A80A08);
    run_vec(v, "ip1.miss");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arp_rx.md
Name: arp_rx

Overview:
- ARP receive parser for the UDP stack; sits after the MAC RX de-encapsulator and receives the ARP payload byte-stream with EtherType 0x0806 already stripped.
- Checks that the target IP matches the local IP and extracts the sender MAC/IP.
- On a matching request, fires a one-cycle reply trigger toward the ARP transmitter.
- On any matching request or reply, publishes the learned peer MAC/IP for the IP/UDP TX path.

Parameters:
- P_SRC_IP, {8'd192,8'd168,8'd10,8'd1}, local IP; value at reset until overwritten through i_src_ip_valid.
- P_ARP_MIN_LEN, 28, minimum ARP bytes before last for a frame to be accepted.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous active-high reset
- i_src_ip  input  32  new local IP
- i_src_ip_valid  input  1  load i_src_ip into the local-IP register
- i_mac_data  input  8  ARP payload byte, network order
- i_mac_last  input  1  final byte of the frame, including padding
- i_mac_valid  input  1  byte qualifier; contiguous for the whole frame
- o_trig_reply  output  1  one-cycle pulse: a valid request for our IP was received
- o_dst_ip  output  32  learned sender protocol address
- o_dst_mac  output  48  learned sender hardware address
- o_dst_valid  output  1  one-cycle pulse: o_dst_ip and o_dst_mac were updated this cycle

Behaviour:
- Reset values: all outputs 0; local IP = P_SRC_IP; byte counter 0; FSM in IDLE.
- Local IP register:
  - Loads on i_src_ip_valid at any time.
  - The comparison uses the register value current in the CHECK state.
- FSM states: IDLE, RECV, CHECK, DROP.
  - IDLE -> RECV on the first i_mac_valid; that byte is counter index 0.
  - RECV:
    - Counter increments on every valid byte.
    - Capture fields by index: 6-7 opcode; 8-13 sender MAC; 14-17 sender IP; 24-27 target IP.
    - Bytes at index 28 and above (padding) are ignored.
  - RECV -> CHECK on a valid byte with i_mac_last when at least P_ARP_MIN_LEN bytes (counter value at last >= 27) have been received.
  - RECV -> DROP on i_mac_last with fewer bytes.
  - RECV -> DROP when i_mac_valid falls without i_mac_last (abort). Nothing is published.
  - DROP -> IDLE on the next cycle.
  - CHECK lasts exactly one cycle, then -> IDLE.
    - If target IP == local IP and opcode == 1: o_trig_reply = 1, o_dst_valid = 1, o_dst_ip/o_dst_mac loaded.
    - If target IP == local IP and opcode == 2: o_dst_valid = 1 and address outputs loaded; no trigger.
    - Otherwise (mismatch, or any other opcode): no outputs change.
- Latency: pulses occur the cycle after the cycle in which the last byte is accepted. A new frame may begin in the CHECK/DROP cycle and is counted from index 0.
- o_dst_ip/o_dst_mac hold their value between updates. Pulses are never longer than one cycle.
- Reset mid-frame: immediate return to IDLE; partial captures are discarded.

Optional Feature:
- ARP_RX_STRICT_CHECK_EN defined: additionally requires HTYPE = 0x0001, PTYPE = 0x0800, HLEN = 6, PLEN = 4 (indices 0-5). Any mismatch suppresses both pulses.
- Not defined: indices 0-5 are ignored; only opcode and target IP are checked.

Decomposition:
- Shared package: ARP opcode constants (REQ = 1, REPLY = 2), HTYPE_ETH, PTYPE_IPV4, field byte offsets, and the minimum length 28. These are shared with the ARP transmitter.
- No sub-module; the FSM, counter, and capture registers live in one module.

Test Plan:
- Request: local 192.168.10.1; request from MAC 00:11:22:33:44:55, IP 192.168.10.2, target 192.168.10.1, padded to 46 bytes -> o_trig_reply and o_dst_valid pulse together one cycle after the last byte; o_dst_mac = 0x001122334455, o_dst_ip = 0xC0A80A02.
- Reply: opcode 2 with the same addresses -> o_dst_valid pulses and outputs update; o_trig_reply stays 0.
- Wrong target: target 192.168.10.9 -> no pulses; outputs keep their previous values.
- Short frame / abort:
  - i_mac_last at index 20 -> DROP, no pulses.
  - i_mac_valid drops at index 10 without last -> no pulses; the next good frame is parsed correctly.
- Back-to-back and IP change: two requests with zero idle cycles -> two trigger pulses. Then load local IP 192.168.10.7 via i_src_ip_valid; a request targeting .7 triggers and one targeting .1 does not.
- Strict check (ARP_RX_STRICT_CHECK_EN defined): PTYPE = 0x86DD with an otherwise valid request -> no pulses. With the macro undefined, the same frame -> trigger.
